// File: rtl/data_mem_resp.sv
// data_mem_resp
//   Data-side memory responder for the MiniMIPS32 memory stage. Services
//   byte-lane-masked loads and stores against an on-chip word RAM and a
//   small memory-mapped timer/LED window, and raises a timer interrupt.
//
// Ports
//   cpu_clk_50M  in   clock, rising edge
//   cpu_rst_n    in   synchronous active-low reset
//   daddr[31:0]  in   byte address (daddr[1:0] does not select lanes)
//   dce          in   access enable; we/dre/din ignored when 0
//   we[3:0]      in   byte-lane write enables (bit k -> din[8k+7:8k])
//   dre[3:0]     in   byte-lane read enables
//   din[31:0]    in   lane-placed store data
//   dm[31:0]     out  registered read data, raw lane order, unselected lanes 0
//   dm_valid     out  one-cycle pulse when dm was updated by a read
//   led[15:0]    out  LED register
//   timer_int    out  level timer interrupt to CP0
module data_mem_resp #(
    parameter int          ADDR_W    = 12,
    parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic [31:0] daddr,
    input  logic        dce,
    input  logic [3:0]  we,
    input  logic [3:0]  dre,
    input  logic [31:0] din,
    output logic [31:0] dm,
    output logic        dm_valid,
    output logic [15:0] led,
    output logic        timer_int
);

    localparam int          RAM_WORDS   = 2 ** ADDR_W;
    localparam logic [15:0] OFF_COUNT   = 16'h0000;
    localparam logic [15:0] OFF_COMPARE = 16'h0004;
    localparam logic [15:0] OFF_LED     = 16'h0008;

    // MMIO registers live in natural byte order; the requester's data is
    // lane-swapped, so both directions pass through this swap.
    function automatic logic [31:0] lane_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] en);
        return {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
    endfunction

    logic [31:0]       mem [RAM_WORDS];
    logic [31:0]       count_q;
    logic [31:0]       count_nxt;
    logic [31:0]       compare_q;
    logic              cmp_en_q;
    logic [15:0]       led_q;

    logic              mmio_hit;
    logic [ADDR_W-1:0] ram_idx;
    logic              wr_req;
    logic              rd_req;
    logic              ram_wr;
    logic              mmio_wr;
    logic              cmp_wr;
    logic              led_wr;
    logic [31:0]       din_sw;
    logic [31:0]       mmio_rdata;
    logic [31:0]       rd_word;

    // Request decode
    assign mmio_hit = (daddr[31:16] == MMIO_BASE);
    assign ram_idx  = daddr[ADDR_W+1:2];
    assign wr_req   = dce && (we != 4'd0);
    // A write in the same request suppresses the read entirely.
    assign rd_req   = dce && (we == 4'd0) && (dre != 4'd0);
    // Reset wins over a write presented on the same edge.
    assign ram_wr   = wr_req && !mmio_hit && cpu_rst_n;
    // MMIO registers only accept full-word stores.
    assign mmio_wr  = wr_req && mmio_hit && (we == 4'hF);
    assign cmp_wr   = mmio_wr && (daddr[15:0] == OFF_COMPARE);
    assign led_wr   = mmio_wr && (daddr[15:0] == OFF_LED);
    assign din_sw   = lane_swap(din);

    assign count_nxt = count_q + 32'd1;

    always_comb begin
        mmio_rdata = 32'd0;
        case (daddr[15:0])
            OFF_COUNT:   mmio_rdata = count_q;
            OFF_COMPARE: mmio_rdata = compare_q;
            OFF_LED:     mmio_rdata = {16'd0, led_q};
            default:     mmio_rdata = 32'd0;
        endcase
    end

    assign rd_word = mmio_hit ? lane_swap(mmio_rdata) : mem[ram_idx];

    // RAM storage: not reset, per-lane write
    always_ff @(posedge cpu_clk_50M) begin
        for (int k = 0; k < 4; k++) begin
            if (ram_wr && we[k]) begin
                mem[ram_idx][8*k +: 8] <= din[8*k +: 8];
            end
        end
    end

    // Read return, timer and LED registers
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            dm        <= 32'd0;
            dm_valid  <= 1'b0;
            led_q     <= 16'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            cmp_en_q  <= 1'b0;
            timer_int <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            dm_valid <= rd_req;
            if (rd_req) begin
                dm <= rd_word & lane_mask(dre);
            end
            if (led_wr) begin
                led_q <= din_sw[15:0];
            end
            // A COMPARE write on the match edge takes priority: the new
            // value loads and the interrupt ends low.
            if (cmp_wr) begin
                compare_q <= din_sw;
                cmp_en_q  <= 1'b1;
                timer_int <= 1'b0;
            end else if (cmp_en_q && (count_q == compare_q)) begin
                timer_int <= 1'b1;
            end
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Testbench for data_mem_resp: directed scenarios plus randomized traffic,
// with read responses checked by a scoreboard fed from a transaction model.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        cpu_rst_n;
    logic [31:0] daddr;
    logic        dce;
    logic [3:0]  we;
    logic [3:0]  dre;
    logic [31:0] din;
    logic [31:0] dm;
    logic        dm_valid;
    logic [15:0] led;
    logic        timer_int;

    always #10 clk = ~clk;

    data_mem_resp dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (cpu_rst_n),
        .daddr       (daddr),
        .dce         (dce),
        .we          (we),
        .dre         (dre),
        .din         (din),
        .dm          (dm),
        .dm_valid    (dm_valid),
        .led         (led),
        .timer_int   (timer_int)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] exp_q [$];
    logic [31:0] mem_m [int];
    logic [31:0] cnt      = 32'd0;  // COUNT value during the current cycle
    logic [31:0] cmp_m    = 32'd0;
    logic [31:0] cw       = 32'd0;  // COUNT value at the last COMPARE write
    logic        cmp_en_m = 1'b0;
    logic [15:0] led_m    = 16'd0;
    logic [31:0] last_dm  = 32'd0;

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] mask32(input logic [3:0] en);
        return {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
    endfunction

    // Interrupt expected iff, since the last COMPARE write edge, some later
    // edge saw COUNT equal to COMPARE.
    function automatic logic exp_timer();
        logic [31:0] dist_match;
        logic [31:0] edges_seen;
        dist_match = cmp_m - cw - 32'd1;
        edges_seen = cnt - cw - 32'd1;
        return cmp_en_m && (dist_match < edges_seen);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_timer();
        check("timer_int", {31'd0, timer_int}, {31'd0, exp_timer()});
    endtask

    // Scoreboard monitor: every dm_valid pulse must match the oldest
    // outstanding expected read.
    always @(negedge clk) begin
        if (dm_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dm_valid: actual=1 expected=0 (no read outstanding) dm=%h", dm);
            end else begin
                check("dm", dm, exp_q.pop_front());
            end
        end
    end

    // Drive one request (called at a falling edge), update the model, and
    // return at the next falling edge.
    task automatic drive(input logic [31:0] a, input logic [3:0] w, input logic [3:0] r,
                         input logic [31:0] d, input logic en);
        logic        hit;
        logic [15:0] off;
        int          idx;
        logic [31:0] v;
        logic [31:0] sw;
        daddr = a;
        we    = w;
        dre   = r;
        din   = d;
        dce   = en;
        if (en && cpu_rst_n) begin
            hit = (a[31:16] == 16'hBFAF);
            off = a[15:0];
            idx = int'(a[13:2]);
            sw  = swap32(d);
            if (w != 4'd0) begin
                if (!hit) begin
                    if (!mem_m.exists(idx)) mem_m[idx] = 'x;
                    for (int k = 0; k < 4; k++)
                        if (w[k]) mem_m[idx][8*k +: 8] = d[8*k +: 8];
                end else if (w == 4'hF) begin
                    if (off == 16'h0004) begin
                        cmp_m    = sw;
                        cmp_en_m = 1'b1;
                        cw       = cnt;
                    end else if (off == 16'h0008) begin
                        led_m = sw[15:0];
                    end
                end
            end else if (r != 4'd0) begin
                if (hit) begin
                    if (off == 16'h0000)      v = cnt;
                    else if (off == 16'h0004) v = cmp_m;
                    else if (off == 16'h0008) v = {16'd0, led_m};
                    else                      v = 32'd0;
                    v = swap32(v);
                end else begin
                    v = mem_m.exists(idx) ? mem_m[idx] : 'x;
                end
                v = v & mask32(r);
                exp_q.push_back(v);
                last_dm = v;
            end
        end
        @(posedge clk);
        if (!cpu_rst_n) begin
            cnt      = 32'd0;
            cmp_m    = 32'd0;
            cmp_en_m = 1'b0;
            led_m    = 16'd0;
            last_dm  = 32'd0;
        end else begin
            cnt = cnt + 32'd1;
        end
        @(negedge clk);
        dce = 1'b0;
        we  = 4'd0;
        dre = 4'd0;
    endtask

    task automatic idle();
        drive(32'd0, 4'd0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        cpu_rst_n = 1'b0;
        repeat (3) idle();
        cpu_rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        logic [3:0]  r;
        int          op;

        cpu_rst_n = 1'b0;
        daddr = 32'd0; dce = 1'b0; we = 4'd0; dre = 4'd0; din = 32'd0;

        // Reset state
        do_reset();
        check("rst_dm", dm, 32'd0);
        check("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_timer", {31'd0, timer_int}, 32'd0);
        idle();
        check_timer();

        // SW then LW, then dm holds with dm_valid low
        drive(32'h0000_0010, 4'hF, 4'h0, 32'h7856_3412, 1'b1);
        drive(32'h0000_0010, 4'h0, 4'hF, 32'h0, 1'b1);
        idle();
        check("lw_pulse_len", {31'd0, dm_valid}, 32'd0);
        check("lw_hold", dm, 32'h7856_3412);

        // SB lane merge
        drive(32'h0000_0011, 4'b0100, 4'h0, 32'hAAAA_AAAA, 1'b1);
        drive(32'h0000_0010, 4'h0, 4'b0011, 32'h0, 1'b1);
        drive(32'h0000_0010, 4'h0, 4'hF, 32'h0, 1'b1);
        idle();
        check("sb_merge_hold", dm, 32'h78AA_3412);

        // MMIO LED, partial write ignored, read back
        drive(32'hBFAF_0008, 4'hF, 4'h0, 32'h3412_0000, 1'b1);
        check("led_write", {16'd0, led}, 32'h0000_1234);
        drive(32'hBFAF_0008, 4'b0011, 4'h0, 32'h5555_5555, 1'b1);
        check("led_partial", {16'd0, led}, {16'd0, led_m});
        drive(32'hBFAF_0008, 4'h0, 4'hF, 32'h0, 1'b1);
        idle();
        check("led_readback_hold", dm, 32'h3412_0000);

        // Read and write together: write lands, read dropped
        drive(32'h0000_0020, 4'hF, 4'hF, 32'hCAFE_F00D, 1'b1);
        check("rw_dm_valid", {31'd0, dm_valid}, 32'd0);
        check("rw_dm_hold", dm, last_dm);
        drive(32'h0000_0020, 4'h0, 4'hF, 32'h0, 1'b1);
        idle();

        // Timer: match at 0x20, rewrite clears, write on match edge wins
        do_reset();
        check_timer();
        drive(32'hBFAF_0004, 4'hF, 4'h0, 32'h2000_0000, 1'b1);
        while (cnt < 32'h24) begin
            idle();
            check_timer();
        end
        check("timer_set", {31'd0, timer_int}, 32'd1);
        drive(32'hBFAF_0004, 4'hF, 4'h0, 32'h0001_0000, 1'b1);
        check("timer_clear", {31'd0, timer_int}, 32'd0);
        while (cnt != 32'h100) begin
            idle();
            check_timer();
        end
        drive(32'hBFAF_0004, 4'hF, 4'h0, 32'h0003_0000, 1'b1);
        check("timer_write_wins", {31'd0, timer_int}, 32'd0);
        repeat (3) begin
            idle();
            check_timer();
        end

        // Randomized traffic over a small RAM window and the MMIO window
        for (int i = 0; i < 16; i++)
            drive({2'b01, 16'($urandom), 8'd0, i[3:0], 2'($urandom)}, 4'hF, 4'h0, $urandom, 1'b1);
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            d  = $urandom;
            w  = 4'($urandom_range(1, 15));
            r  = 4'($urandom_range(1, 15));
            a  = {2'b01, 16'($urandom), 8'd0, 4'($urandom), 2'($urandom)};
            if (op == 0) begin
                drive($urandom, 4'($urandom), 4'($urandom), d, 1'b0);
            end else if (op <= 3) begin
                drive(a, w, 4'h0, d, 1'b1);
            end else if (op <= 6) begin
                drive(a, 4'h0, r, d, 1'b1);
            end else if (op == 7) begin
                a = {16'hBFAF, 12'd0, 2'($urandom), 2'b00};
                drive(a, ($urandom_range(0, 1) == 0) ? 4'hF : w, 4'h0, d, 1'b1);
            end else begin
                a = {16'hBFAF, 12'd0, 2'($urandom), 2'b00};
                drive(a, 4'h0, r, d, 1'b1);
            end
            check_timer();
        end

        // COUNT wrap via a preset of the next-count value
        do_reset();
        force dut.count_nxt = 32'hFFFF_FFFE;
        idle();
        release dut.count_nxt;
        cnt = 32'hFFFF_FFFE;
        drive(32'hBFAF_0000, 4'h0, 4'hF, 32'h0, 1'b1);
        drive(32'hBFAF_0000, 4'h0, 4'hF, 32'h0, 1'b1);
        drive(32'hBFAF_0000, 4'h0, 4'hF, 32'h0, 1'b1);
        idle();
        check("count_wrap_hold", dm, 32'h0000_0000);
        check_timer();

        // Reset mid-operation
        drive(32'h0000_0040, 4'hF, 4'h0, 32'h1122_3344, 1'b1);
        drive(32'hBFAF_0008, 4'hF, 4'h0, 32'h00AB_0000, 1'b1);
        drive(32'h0000_0010, 4'h0, 4'hF, 32'h0, 1'b1);
        cpu_rst_n = 1'b0;
        drive(32'h0000_0040, 4'hF, 4'h0, 32'hDEAD_BEEF, 1'b1);
        drive(32'h0000_0010, 4'h0, 4'hF, 32'h0, 1'b1);
        check("midrst_dm", dm, 32'd0);
        check("midrst_dm_valid", {31'd0, dm_valid}, 32'd0);
        check("midrst_led", {16'd0, led}, 32'd0);
        check("midrst_timer", {31'd0, timer_int}, 32'd0);
        cpu_rst_n = 1'b1;
        drive(32'h0000_0040, 4'h0, 4'hF, 32'h0, 1'b1);
        drive(32'hBFAF_0000, 4'h0, 4'hF, 32'h0, 1'b1);
        idle();
        check("midrst_count_restart", dm, 32'h0100_0000);
        idle();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL outstanding_reads: actual=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
